// File: rtl/uart_pkg.sv
// Shared UART types and helpers, used by the RX and TX blocks.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

  // Clocks per oversample tick; integer division, so 0 means the clock is too slow.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider: tick is high for one clk every DIV clks.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with valid/ready output and error pulses.
// Define UART_PARITY_EN to add one even parity bit after the data bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] HALF  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

  generate
    if (DIV < 1 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9)
    begin : g_param_err
      $error("uart_rx: unsupported CLK_HZ/BAUD/OVERSAMPLE/DATA_BITS combination");
    end
  endgenerate

  logic                 tick;
  logic [1:0]           sync;
  logic                 rx_s;
  uart_state_t          state;
  logic [SW-1:0]        scnt;
  logic [BW-1:0]        bidx;
  logic [DATA_BITS-1:0] shreg;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchroniser, reset to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx};
  end
  assign rx_s = sync[1];

`ifdef UART_PARITY_EN
  logic par_bit;
  logic par_bad;
  assign par_bad = ^{shreg, par_bit};
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      scnt      <= '0;
      bidx      <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err <= 1'b0;
`endif
      // A load later in this block overrides the drop, so accept+load keeps valid high.
      if (valid && ready) valid <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: if (!rx_s) begin
            state <= START;
            scnt  <= '0;
          end
          START: if (scnt == HALF) begin
            scnt  <= '0;
            bidx  <= '0;
            state <= rx_s ? IDLE : DATA;
          end else scnt <= scnt + 1'b1;
          DATA: if (scnt == LAST) begin
            scnt  <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bidx == BLAST) begin
              bidx  <= '0;
`ifdef UART_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else bidx <= bidx + 1'b1;
          end else scnt <= scnt + 1'b1;
`ifdef UART_PARITY_EN
          PARITY: if (scnt == LAST) begin
            scnt    <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else scnt <= scnt + 1'b1;
`else
          PARITY: state <= IDLE;
`endif
          // Decide at mid stop bit and return to IDLE so a back-to-back start is caught.
          STOP: if (scnt == LAST) begin
            scnt  <= '0;
            state <= IDLE;
            if (!rx_s) frame_err <= 1'b1;
`ifdef UART_PARITY_EN
            else if (par_bad) parity_err <= 1'b1;
`endif
            else if (valid && !ready) overrun <= 1'b1;
            else begin
              data  <= shreg;
              valid <= 1'b1;
            end
          end else scnt <= scnt + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx against a frame-level reference model.
module tb_uart_rx;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int BIT    = CLK_HZ / BAUD;
`ifdef UART_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, overrun, parity_err;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed side: words transferred and error pulse counts.
  logic [7:0] got_q[$];
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int rise_cyc = 0;
  logic vprev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) got_q.push_back(data);
      if (frame_err)  fe_cnt++;
      if (overrun)    ov_cnt++;
      if (parity_err) pe_cnt++;
      if (valid && !vprev) rise_cyc = cyc;
    end
    vprev = valid;
  end

  // Reference model: one holding register, frames resolved in arrival order.
  logic [7:0] exp_q[$];
  int exp_fe = 0, exp_ov = 0, exp_pe = 0;
  bit full = 1'b0;
  logic [7:0] held;
  int t0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic model_frame(input logic [7:0] w, input bit stop_ok, input bit par_ok);
    if (!stop_ok)                exp_fe++;
    else if (PAR && !par_ok)     exp_pe++;
    else if (full && !ready)     exp_ov++;
    else if (ready)              exp_q.push_back(w);
    else begin full = 1'b1; held = w; end
  endtask

  task automatic set_ready(input logic v);
    ready = v;
    if (v && full) begin exp_q.push_back(held); full = 1'b0; end
  endtask

  // Bad stop bits are held low for 12 clks: sampled low at mid-bit, released before a re-trigger.
  task automatic send_frame(input logic [7:0] w, input bit stop_ok, input bit par_ok);
    t0 = cyc;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(w[i], BIT);
    if (PAR) drive_bit((^w) ^ !par_ok, BIT);
    if (stop_ok) drive_bit(1'b1, BIT);
    else begin drive_bit(1'b0, 12); rx = 1'b1; end
    model_frame(w, stop_ok, par_ok);
  endtask

  task automatic check_all();
    chk("word_count", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) chk("data", got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    chk("frame_err_cnt", fe_cnt, exp_fe);
    chk("overrun_cnt", ov_cnt, exp_ov);
    chk("parity_err_cnt", pe_cnt, exp_pe);
  endtask

  initial begin
    int lat, gap;
    logic [7:0] w;
    bit sok, pok;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_parity_err", parity_err, 1'b0);
    rst = 1'b0;
    drive_bit(1'b1, 20);

    // Single good frame and output latency relative to the stop bit.
    send_frame(8'hA5, 1'b1, 1'b1);
    lat = rise_cyc - (t0 + BIT * (9 + int'(PAR)));
    chk("latency_window", (lat >= 6 && lat <= 14), 1'b1);
    drive_bit(1'b1, 10);
    check_all();

    // False start.
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 40);
    chk("false_start_valid", valid, 1'b0);
    check_all();

    // Framing error.
    send_frame(8'h3C, 1'b0, 1'b1);
    drive_bit(1'b1, 24);
    chk("frame_err_valid", valid, 1'b0);
    check_all();

    // Back-to-back frames with the consumer stalled.
    set_ready(1'b0);
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    drive_bit(1'b1, 4);
    chk("held_valid", valid, 1'b1);
    chk("held_data", data, 8'h11);
    check_all();
    set_ready(1'b1);
    @(posedge clk); #1;
    chk("valid_drop", valid, 1'b0);
    drive_bit(1'b1, 4);
    check_all();

    // Asynchronous reset in the middle of a frame.
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, BIT);
    drive_bit(1'b1, 8);
    #3 rst = 1'b1;
    #20;
    chk("midrst_valid", valid, 1'b0);
    chk("midrst_data", data, 8'h00);
    rx = 1'b1;
    #10 rst = 1'b0;
    full = 1'b0;
    @(posedge clk); #1;
    drive_bit(1'b1, 20);
    send_frame(8'h42, 1'b1, 1'b1);
    drive_bit(1'b1, 6);
    check_all();

`ifdef UART_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    drive_bit(1'b1, 6);
    check_all();
    send_frame(8'h07, 1'b1, 1'b0);
    drive_bit(1'b1, 6);
    chk("parity_bad_valid", valid, 1'b0);
    check_all();
`endif

    // Randomised traffic: payloads, stop/parity faults, gaps and consumer stalls.
    for (int n = 0; n < 40; n++) begin
      w   = 8'($urandom);
      sok = ($urandom_range(0, 5) != 0);
      pok = PAR ? ($urandom_range(0, 5) != 0) : 1'b1;
      send_frame(w, sok, pok);
      if (!sok) gap = 20 + $urandom_range(0, 10);
      else      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20);
      if (gap > 0) begin
        set_ready($urandom_range(0, 3) != 0);
        drive_bit(1'b1, gap);
        check_all();
      end
    end
    set_ready(1'b1);
    drive_bit(1'b1, 10);
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
